// File: rtl/debug_hex_display.sv
// Debug readout: selects one of NUM_CH packed channels, manually or by timed auto-scroll, and
// drives active-low gfedcba seven-segment patterns with optional leading-zero blanking.
module debug_hex_display #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_WIDTH = 16,
  parameter int unsigned DWELL    = 4194304,
  parameter int unsigned SW_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
  parameter int unsigned NDIG     = CH_WIDTH / 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  input  logic [SW_W-1:0]            sel,
  input  logic                       auto,
  input  logic                       freeze,
  input  logic                       blank_en,
  output logic [NDIG*7-1:0]          seg,
  output logic [SW_W-1:0]            cur_ch,
  output logic                       wrap
);

  localparam int unsigned     CntW    = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);
  localparam logic [SW_W-1:0] ChLast  = SW_W'(NUM_CH - 1);

  logic [SW_W-1:0]     cur_ch_q, cur_ch_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CH_WIDTH-1:0] val_q, val_d;
  logic                wrap_q, wrap_d;
  logic                auto_q;
  logic [CH_WIDTH-1:0] ch_sel;

  assign cur_ch = cur_ch_q;
  assign wrap   = wrap_q;

  always_comb begin
    ch_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur_ch_q == SW_W'(i)) ch_sel = ch_data[i*CH_WIDTH +: CH_WIDTH];
    end
  end

  always_comb begin
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
    val_d    = val_q;
    wrap_d   = 1'b0;
    if (!freeze) begin
      // Snapshot follows the channel latched last cycle, not the one being selected now.
      val_d = ch_sel;
      if (!auto) begin
        cur_ch_d = (sel > ChLast) ? ChLast : sel;
        cnt_d    = '0;
      end else if (!auto_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        cnt_d = '0;
        if (cur_ch_q == ChLast) begin
          cur_ch_d = '0;
          wrap_d   = 1'b1;
        end else begin
          cur_ch_d = cur_ch_q + SW_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ch_q <= '0;
      cnt_q    <= '0;
      val_q    <= '0;
      wrap_q   <= 1'b0;
      auto_q   <= 1'b0;
    end else begin
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      wrap_q   <= wrap_d;
      auto_q   <= auto;
    end
  end

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h18;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  logic       lead;
  logic [3:0] nib;

  // Scan from the most significant digit; lead stays set until the first non-zero nibble.
  always_comb begin
    seg  = '0;
    lead = 1'b1;
    nib  = '0;
    for (int k = int'(NDIG) - 1; k >= 0; k--) begin
      nib = val_q[k*4 +: 4];
      if (nib != 4'd0 || k == 0) lead = 1'b0;
      seg[k*7 +: 7] = (blank_en && lead) ? 7'h7F : hex_glyph(nib);
    end
  end

endmodule
